// File: rtl/wb_pipe_reg_pkg.sv
// rtl/wb_pipe_reg_pkg.sv - shared M/W pipeline constants and W-stage bundle type
package wb_pipe_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] REG_NONE = '0;

    typedef struct packed {
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valM;
        logic [REG_W-1:0]  dstE;
        logic [REG_W-1:0]  dstM;
        logic              weE;
        logic              weM;
    } w_bundle_t;

    localparam w_bundle_t W_NOP = '0;

endpackage

// File: rtl/wb_pipe_reg_if.sv
// rtl/wb_pipe_reg_if.sv - M-stage inputs and W-stage outputs of the M/W pipeline register
interface wb_pipe_reg_if #(
    parameter int DATA_W = wb_pipe_reg_pkg::DATA_W,
    parameter int REG_W  = wb_pipe_reg_pkg::REG_W
);
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] m_valM;
    logic [REG_W-1:0]  M_dstE;
    logic [REG_W-1:0]  M_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [REG_W-1:0]  W_dstE;
    logic [REG_W-1:0]  W_dstM;
    logic              W_weE;
    logic              W_weM;

    modport master (
        output M_valE, m_valM, M_dstE, M_dstM,
        input  W_valE, W_valM, W_dstE, W_dstM, W_weE, W_weM
    );

    modport slave (
        input  M_valE, m_valM, M_dstE, M_dstM,
        output W_valE, W_valM, W_dstE, W_dstM, W_weE, W_weM
    );
endinterface

// File: rtl/wb_pipe_reg_field_reg.sv
// rtl/wb_pipe_reg_field_reg.sv - one pipeline field flop with reset, bubble and stall
module pipe_field_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] NOP_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Priority: reset, then bubble, then stall; bubble beats stall so a
    // squashed instruction can never linger in a held stage.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= NOP_VAL;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - M/W pipeline register feeding the register-file write port
module wb_pipe_reg #(
    parameter int DATA_W = wb_pipe_reg_pkg::DATA_W,
    parameter int REG_W  = wb_pipe_reg_pkg::REG_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_stall,
    input  logic        W_bubble,
    wb_pipe_reg_if.slave bus
);
    import wb_pipe_reg_pkg::REG_NONE;

    logic we_e_d;
    logic we_m_d;

    // Write enables are registered rather than decoded from W_dst* so the
    // register file sees them straight off a flop.
    assign we_e_d = (bus.M_dstE != REG_W'(REG_NONE));
    assign we_m_d = (bus.M_dstM != REG_W'(REG_NONE));

    pipe_field_reg #(.W(DATA_W)) u_val_e (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(bus.M_valE), .q(bus.W_valE)
    );

    pipe_field_reg #(.W(DATA_W)) u_val_m (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(bus.m_valM), .q(bus.W_valM)
    );

    pipe_field_reg #(.W(REG_W)) u_dst_e (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(bus.M_dstE), .q(bus.W_dstE)
    );

    pipe_field_reg #(.W(REG_W)) u_dst_m (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(bus.M_dstM), .q(bus.W_dstM)
    );

    pipe_field_reg #(.W(1)) u_we_e (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(we_e_d), .q(bus.W_weE)
    );

    pipe_field_reg #(.W(1)) u_we_m (
        .clk(clk), .reset(reset), .stall(W_stall), .bubble(W_bubble),
        .d(we_m_d), .q(bus.W_weM)
    );

endmodule

// File: tb/tb_wb_pipe_reg.sv
// tb/tb_wb_pipe_reg.sv - directed self-checking bench for wb_pipe_reg
module tb_wb_pipe_reg;
    import wb_pipe_reg_pkg::*;

    logic clk;
    logic reset;
    logic W_stall;
    logic W_bubble;
    int   total;
    int   bad;

    w_bundle_t expd;

    wb_pipe_reg_if bus ();

    wb_pipe_reg dut (
        .clk(clk),
        .reset(reset),
        .W_stall(W_stall),
        .W_bubble(W_bubble),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valE"}, bus.W_valE, expd.valE);
        check({tag, ".valM"}, bus.W_valM, expd.valM);
        check({tag, ".dstE"}, 32'(bus.W_dstE), 32'(expd.dstE));
        check({tag, ".dstM"}, 32'(bus.W_dstM), 32'(expd.dstM));
        check({tag, ".weE"}, 32'(bus.W_weE), 32'(expd.weE));
        check({tag, ".weM"}, 32'(bus.W_weM), 32'(expd.weM));
    endtask

    task automatic drive(input logic [31:0] ve, input logic [31:0] vm,
                         input logic [4:0] de, input logic [4:0] dm);
        bus.M_valE = ve;
        bus.m_valM = vm;
        bus.M_dstE = de;
        bus.M_dstM = dm;
    endtask

    // Step one edge, then sample 1 ns later, clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        drive(32'hDEADBEEF, 32'h12345678, 5'd7, 5'd9);
        #5;
        step();
        expd = W_NOP;
        check_all("reset");

        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            drive(32'(i), 32'(i), 5'(i), 5'(i));
            step();
            expd = '{valE: 32'(i), valM: 32'(i), dstE: 5'(i), dstM: 5'(i), weE: 1'b1, weM: 1'b1};
            check_all($sformatf("flow%0d", i));
        end

        drive(32'hA5A5A5A5, 32'h00000011, 5'd3, 5'd2);
        step();
        expd = '{valE: 32'hA5A5A5A5, valM: 32'h11, dstE: 5'd3, dstM: 5'd2, weE: 1'b1, weM: 1'b1};
        check_all("preload");

        W_stall = 1'b1;
        drive(32'h5A5A5A5A, 32'h00000022, 5'd4, 5'd0);
        step();
        check_all("stall1");
        step();
        check_all("stall2");

        W_stall = 1'b0;
        step();
        expd = '{valE: 32'h5A5A5A5A, valM: 32'h22, dstE: 5'd4, dstM: 5'd0, weE: 1'b1, weM: 1'b0};
        check_all("unstall");

        W_bubble = 1'b1;
        drive(32'd5, 32'd5, 5'd5, 5'd6);
        step();
        expd = W_NOP;
        check_all("bubble");

        W_bubble = 1'b0;
        drive(32'd9, 32'd10, 5'd9, 5'd10);
        step();
        expd = '{valE: 32'd9, valM: 32'd10, dstE: 5'd9, dstM: 5'd10, weE: 1'b1, weM: 1'b1};
        check_all("reload");

        W_bubble = 1'b1;
        W_stall  = 1'b1;
        step();
        expd = W_NOP;
        check_all("bubble_stall");

        W_bubble = 1'b0;
        W_stall  = 1'b0;
        drive(32'hFFFFFFFF, 32'h00000077, 5'd0, 5'd8);
        step();
        expd = '{valE: 32'hFFFFFFFF, valM: 32'h77, dstE: 5'd0, dstM: 5'd8, weE: 1'b0, weM: 1'b1};
        check_all("zero_dst");

        drive(32'h0BADF00D, 32'hCAFEBABE, 5'd31, 5'd0);
        step();
        expd = '{valE: 32'h0BADF00D, valM: 32'hCAFEBABE, dstE: 5'd31, dstM: 5'd0, weE: 1'b1, weM: 1'b0};
        check_all("dst31");

        W_stall = 1'b1;
        reset   = 1'b1;
        step();
        expd = W_NOP;
        check_all("reset_stall");

        W_stall = 1'b0;
        reset   = 1'b0;
        drive(32'h13579BDF, 32'h2468ACE0, 5'd1, 5'd17);
        step();
        expd = '{valE: 32'h13579BDF, valM: 32'h2468ACE0, dstE: 5'd1, dstM: 5'd17, weE: 1'b1, weM: 1'b1};
        check_all("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
- Pipeline register between the Memory (M) and Write-back (W) stages of the pipelined MIPS CPU.
- Captures the ALU result, the memory-read value and both destination register numbers every clock, and presents them to the register-file write port.
- Supports stall (hold) and bubble (insert NOP) control from the hazard unit.
- Provides registered write-enable flags derived from the destination fields.

Parameters:
- DATA_W, 32, width of valE/valM data words
- REG_W, 5, width of register-number fields; register 0 means "no destination"

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- W_stall  input  1  hold current contents
- W_bubble  input  1  load NOP (all-zero) contents
- M_valE  input  DATA_W  ALU result from M stage
- m_valM  input  DATA_W  data-memory read value
- M_dstE  input  REG_W  destination register for valE
- M_dstM  input  REG_W  destination register for valM
- W_valE  output  DATA_W  registered valE
- W_valM  output  DATA_W  registered valM
- W_dstE  output  REG_W  registered dstE
- W_dstM  output  REG_W  registered dstM
- W_weE  output  1  registered (dstE != 0)
- W_weM  output  1  registered (dstM != 0)

Behaviour:
- All outputs are flops updated only on the rising edge of clk; no combinational path from inputs to outputs; latency exactly 1 cycle.
- Priority at each rising edge is reset > W_bubble > W_stall > normal load.
- reset=1: all outputs become 0; W_weE = W_weM = 0.
- W_bubble=1 (and reset=0): all outputs become 0, equivalent to a NOP with no register write. Bubble wins over a simultaneous W_stall.
- W_stall=1 (and no reset or bubble): all outputs hold their previous values, including the we flags.
- Otherwise: W_valE<=M_valE, W_valM<=m_valM, W_dstE<=M_dstE, W_dstM<=M_dstM, W_weE<=(M_dstE!=0), W_weM<=(M_dstM!=0).
- Data is passed bit-exact; there is no arithmetic, truncation or sign extension.
- Register 0 as a destination always yields we=0, so writes to $0 are suppressed.
- Before the first reset, output values are unspecified; the bench must apply reset or tolerate X until the first load edge.
- Inputs changing mid-cycle have no effect until the next rising edge.
- Deasserting reset takes effect at the next edge: the first edge with reset=0 performs the normal, stall or bubble action.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and REG_W constants
  - REG_NONE = 0
  - a W-stage bundle struct {valE, valM, dstE, dstM, weE, weM} with a NOP constant (all zero)
- One natural sub-module, pipe_field_reg: a width-parameterised flop with reset, bubble-to-constant and stall-enable. It is instantiated once per field.

Test Plan:
- Reset: reset=1 for one edge with inputs 0xDEADBEEF/0x12345678/7/9 -> all outputs 0 and we flags 0 after the edge.
- Normal flow: 20 ns clock; on successive edges apply valE=valM=dstE=dstM=1,2,...,7, changed away from the edges -> after each edge outputs equal the value applied before it, one-cycle latency; weE=weM=1.
- Stall: load valE=0xA5A5A5A5, dstE=3; then W_stall=1 with inputs changed to 0x5A5A5A5A, dstE=4 for 2 edges -> outputs stay 0xA5A5A5A5/3; releasing the stall loads 0x5A5A5A5A/4 on the next edge.
- Bubble: W_bubble=1 with inputs valE=5, dstE=5, dstM=6 -> outputs 0, weE=weM=0. With W_bubble=W_stall=1 together -> outputs 0 (bubble priority).
- Zero destination: dstE=0, dstM=8, valE=0xFFFFFFFF -> W_dstE=0, W_weE=0, W_weM=1, W_valE=0xFFFFFFFF.
- Reset mid-stream with W_stall=1 -> outputs cleared to 0 on that edge (reset priority).
